uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one memory-mapped UART transmitter between two byte requesters.
// After reset it programs the baud divisor, then repeatedly:
//   accepts one byte (round-robin on contention),
//   polls STATUS until the transmitter is ready (bit 0),
//   writes the byte to DATA.
// If STATUS never reports ready within POLL_LIMIT polls, the byte is dropped
// and the owning requester is told through a one-cycle drop pulse.
//
// Ports
//   clk                   system clock, rising edge
//   reset                 synchronous active-high reset
//   req_valid_in[1:0]     per-requester byte available
//   req_data_in[15:0]     requester 0 byte in [7:0], requester 1 byte in [15:8]
//   req_ready_out[1:0]    per-requester accept (valid & ready = transfer)
//   uart_address_out      UART bus address
//   uart_sel_out          UART bus select
//   uart_read_out         UART bus read strobe
//   uart_write_mask_out   UART bus byte-write mask
//   uart_write_value_out  UART bus write data
//   uart_read_value_in    UART bus read data (only STATUS bit 0 is used)
//   uart_ready_in         UART bus completion (sel & ready = command done)
//   busy_out              high whenever the block is not idle
//   drop_out[1:0]         one-cycle pulse naming the requester whose byte was dropped

module uart_tx_arbiter #(
  parameter logic [31:0] UART_BASE    = 32'h0000_0000,
  parameter logic [15:0] CLK_DIV_INIT = 16'd104,
  parameter logic [15:0] POLL_LIMIT   = 16'd65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid_in,
  input  logic [15:0] req_data_in,
  output logic [1:0]  req_ready_out,
  output logic [31:0] uart_address_out,
  output logic        uart_sel_out,
  output logic        uart_read_out,
  output logic [3:0]  uart_write_mask_out,
  output logic [31:0] uart_write_value_out,
  input  logic [31:0] uart_read_value_in,
  input  logic        uart_ready_in,
  output logic        busy_out,
  output logic [1:0]  drop_out
);

  localparam logic [15:0] PollLast = POLL_LIMIT - 16'd1;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StPoll,
    StWrite
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic        grant_q, grant_d;
  logic        lastGrant_q, lastGrant_d;
  logic [15:0] pollCount_q, pollCount_d;
  logic [1:0]  drop_q, drop_d;
  logic        resetHold_q;
  logic        winner;
  logic        unusedReadBits;

  // Only the transmitter-ready flag of STATUS matters here.
  assign unusedReadBits = ^uart_read_value_in[31:1];

  // On contention the requester that was not served last goes next; a lone
  // requester always wins.
  assign winner = (&req_valid_in) ? ~lastGrant_q : req_valid_in[1];

  assign busy_out = (state_q != StIdle);
  assign drop_out = drop_q;

  // State register. resetHold_q remembers that reset was seen on the last
  // edge so the divisor write is held back (bus shows idle values) until
  // reset has actually been released.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StInit;
      byte_q      <= 8'h00;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      pollCount_q <= 16'h0000;
      drop_q      <= 2'b00;
      resetHold_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      pollCount_q <= pollCount_d;
      drop_q      <= drop_d;
      resetHold_q <= 1'b0;
    end
  end

  // Next-state and bus outputs. Each bus-owning state keeps its command on
  // the bus until uart_ready_in completes it.
  always_comb begin
    state_d              = state_q;
    byte_d               = byte_q;
    grant_d              = grant_q;
    lastGrant_d          = lastGrant_q;
    pollCount_d          = pollCount_q;
    drop_d               = 2'b00;
    req_ready_out        = 2'b00;
    uart_sel_out         = 1'b0;
    uart_read_out        = 1'b0;
    uart_address_out     = 32'h0000_0000;
    uart_write_mask_out  = 4'b0000;
    uart_write_value_out = 32'h0000_0000;

    case (state_q)
      StInit: begin
        if (!resetHold_q) begin
          uart_sel_out         = 1'b1;
          uart_address_out     = UART_BASE;
          uart_write_mask_out  = 4'b0011;
          uart_write_value_out = {16'h0000, CLK_DIV_INIT};
          if (uart_ready_in) begin
            state_d = StIdle;
          end
        end
      end

      StIdle: begin
        if (|req_valid_in) begin
          req_ready_out = winner ? 2'b10 : 2'b01;
          byte_d        = winner ? req_data_in[15:8] : req_data_in[7:0];
          grant_d       = winner;
          pollCount_d   = 16'h0000;
          state_d       = StPoll;
        end
      end

      StPoll: begin
        uart_sel_out     = 1'b1;
        uart_read_out    = 1'b1;
        uart_address_out = UART_BASE + 32'h4;
        if (uart_ready_in) begin
          if (uart_read_value_in[0]) begin
            state_d = StWrite;
          end else if (pollCount_q == PollLast) begin
            drop_d[grant_q] = 1'b1;
            lastGrant_d     = grant_q;
            state_d         = StIdle;
          end else if (pollCount_q != 16'hFFFF) begin
            pollCount_d = pollCount_q + 16'd1;
          end
        end
      end

      StWrite: begin
        uart_sel_out         = 1'b1;
        uart_address_out     = UART_BASE + 32'h8;
        uart_write_mask_out  = 4'b0001;
        uart_write_value_out = {24'h000000, byte_q};
        if (uart_ready_in) begin
          lastGrant_d = grant_q;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d = StInit;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//
// Directed checks of the reset/divisor sequence, a single zero-wait byte and
// a reset that aborts an in-flight byte, followed by a randomized run where
// two requesters compete for a UART with random wait states and random
// STATUS behaviour. The random run is scored by a transaction-level model:
// which requester should win, which byte each DATA write must carry, how
// many STATUS polls are allowed before a drop, and when drop_out must pulse.

module tb_uart_tx_arbiter;

  localparam logic [31:0] Base      = 32'h0000_0000;
  localparam int          PollLimit = 8;
  localparam int          NumBytes  = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid_in;
  logic [15:0] req_data_in;
  logic [1:0]  req_ready_out;
  logic [31:0] uart_address_out;
  logic        uart_sel_out;
  logic        uart_read_out;
  logic [3:0]  uart_write_mask_out;
  logic [31:0] uart_write_value_out;
  logic [31:0] uart_read_value_in;
  logic        uart_ready_in;
  logic        busy_out;
  logic [1:0]  drop_out;

  int compareCount = 0;
  int failCount    = 0;

  // Reference model state
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [1:0]  vld;
  logic        modelLastGrant;
  logic        inFlight;
  logic        modelGrant;
  logic [7:0]  expByte;
  int          pollsDone;
  logic        awaitingWrite;
  int          zerosLeft;
  logic [1:0]  pendingDrop;
  int          acceptCount;
  int          writeCount;
  int          dropCount;
  logic        prevStall;
  logic [69:0] prevBus;

  uart_tx_arbiter #(
    .UART_BASE   (Base),
    .CLK_DIV_INIT(16'd104),
    .POLL_LIMIT  (16'(PollLimit))
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid_in        (req_valid_in),
    .req_data_in         (req_data_in),
    .req_ready_out       (req_ready_out),
    .uart_address_out    (uart_address_out),
    .uart_sel_out        (uart_sel_out),
    .uart_read_out       (uart_read_out),
    .uart_write_mask_out (uart_write_mask_out),
    .uart_write_value_out(uart_write_value_out),
    .uart_read_value_in  (uart_read_value_in),
    .uart_ready_in       (uart_ready_in),
    .busy_out            (busy_out),
    .drop_out            (drop_out)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Hold reset for n edges with a zero-wait UART, then check the idle cycle
  // after reset and the divisor write that follows release.
  task automatic resetDut(input int n);
    reset         = 1'b1;
    req_valid_in  = 2'b00;
    req_data_in   = 16'h0000;
    uart_ready_in = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rstSel", uart_sel_out, 1'b0);
    checkOutput("rstRead", uart_read_out, 1'b0);
    checkOutput("rstAddr", uart_address_out, 32'h0);
    checkOutput("rstMask", uart_write_mask_out, 4'h0);
    checkOutput("rstDrop", drop_out, 2'b00);
    @(negedge clk);
    checkOutput("initSel", uart_sel_out, 1'b1);
    checkOutput("initRead", uart_read_out, 1'b0);
    checkOutput("initAddr", uart_address_out, Base);
    checkOutput("initMask", uart_write_mask_out, 4'b0011);
    checkOutput("initValue", uart_write_value_out, 32'h0000_0068);
    @(negedge clk);
    checkOutput("initIdleBusy", busy_out, 1'b0);
  endtask

  // Drive requesters and the UART for the coming cycle.
  task automatic applyStimulus();
    logic [31:0] rv;
    if (!vld[0] && q0.size() > 0 && $urandom_range(0, 3) != 0) vld[0] = 1'b1;
    if (!vld[1] && q1.size() > 0 && $urandom_range(0, 3) != 0) vld[1] = 1'b1;
    req_valid_in = vld;
    req_data_in  = {(q1.size() > 0) ? q1[0] : 8'h00, (q0.size() > 0) ? q0[0] : 8'h00};
    uart_ready_in = ($urandom_range(0, 3) != 0);
    rv    = $urandom();
    rv[0] = (zerosLeft == 0);
    uart_read_value_in = rv;
  endtask

  // Score one cycle of DUT behaviour against the model.
  task automatic observe();
    logic [1:0]  arb;
    logic [69:0] bus;
    bus = {uart_address_out, uart_sel_out, uart_read_out, uart_write_mask_out,
           uart_write_value_out};

    checkOutput("drop", drop_out, pendingDrop);
    pendingDrop = 2'b00;
    checkOutput("busy", busy_out, inFlight);
    checkOutput("rdData", (uart_sel_out && uart_read_out &&
                           uart_address_out == Base + 32'h8), 1'b0);
    if (prevStall) checkOutput("stable", (bus != prevBus), 1'b0);

    if (req_valid_in == 2'b11) arb = modelLastGrant ? 2'b01 : 2'b10;
    else                       arb = req_valid_in;
    checkOutput("grant", req_ready_out, inFlight ? 2'b00 : arb);

    if (uart_sel_out && uart_ready_in && uart_read_out) begin
      checkOutput("pollAddr", uart_address_out, Base + 32'h4);
      checkOutput("pollMask", uart_write_mask_out, 4'h0);
      checkOutput("pollInFlight", inFlight, 1'b1);
      checkOutput("pollAfterOk", awaitingWrite, 1'b0);
      pollsDone++;
      if (uart_read_value_in[0]) begin
        awaitingWrite = 1'b1;
      end else begin
        if (zerosLeft > 0) zerosLeft--;
        if (pollsDone >= PollLimit) begin
          pendingDrop = modelGrant ? 2'b10 : 2'b01;
          inFlight       = 1'b0;
          modelLastGrant = modelGrant;
          dropCount++;
        end
      end
    end else if (uart_sel_out && uart_ready_in) begin
      checkOutput("wrAddr", uart_address_out, Base + 32'h8);
      checkOutput("wrMask", uart_write_mask_out, 4'b0001);
      checkOutput("wrValue", uart_write_value_out, {24'h0, expByte});
      checkOutput("wrReady", awaitingWrite, 1'b1);
      inFlight       = 1'b0;
      awaitingWrite  = 1'b0;
      modelLastGrant = modelGrant;
      writeCount++;
    end

    if ((req_ready_out & req_valid_in) != 2'b00) begin
      modelGrant = req_ready_out[1];
      if (modelGrant) expByte = q1.pop_front();
      else            expByte = q0.pop_front();
      vld[modelGrant] = 1'b0;
      inFlight      = 1'b1;
      pollsDone     = 0;
      awaitingWrite = 1'b0;
      zerosLeft     = ($urandom_range(0, 4) == 0) ? 1000 : int'($urandom_range(0, 7));
      acceptCount++;
    end

    prevStall = uart_sel_out && !uart_ready_in;
    prevBus   = bus;
  endtask

  initial begin
    int dataWrites;
    reset              = 1'b1;
    req_valid_in       = 2'b00;
    req_data_in        = 16'h0000;
    uart_ready_in      = 1'b1;
    uart_read_value_in = 32'h0;

    resetDut(2);

    // Single zero-wait byte from requester 0.
    @(posedge clk); #1;
    req_valid_in       = 2'b01;
    req_data_in        = 16'h0041;
    uart_read_value_in = 32'h1;
    @(negedge clk);
    checkOutput("acc0Ready", req_ready_out, 2'b01);
    @(posedge clk); #1;
    req_valid_in = 2'b00;
    @(negedge clk);
    checkOutput("z0PollSel", uart_sel_out, 1'b1);
    checkOutput("z0PollRead", uart_read_out, 1'b1);
    checkOutput("z0PollAddr", uart_address_out, Base + 32'h4);
    @(negedge clk);
    checkOutput("z0WrRead", uart_read_out, 1'b0);
    checkOutput("z0WrAddr", uart_address_out, Base + 32'h8);
    checkOutput("z0WrMask", uart_write_mask_out, 4'b0001);
    checkOutput("z0WrValue", uart_write_value_out, 32'h0000_0041);
    @(negedge clk);
    checkOutput("z0IdleBusy", busy_out, 1'b0);
    checkOutput("z0NoDrop", drop_out, 2'b00);

    // Reset while a byte from requester 1 is being polled.
    @(posedge clk); #1;
    req_valid_in       = 2'b10;
    req_data_in        = 16'h7700;
    uart_read_value_in = 32'h0;
    @(negedge clk);
    checkOutput("acc1Ready", req_ready_out, 2'b10);
    @(posedge clk); #1;
    req_valid_in = 2'b00;
    @(negedge clk);
    checkOutput("abPollRead", uart_read_out, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abIdleSel", uart_sel_out, 1'b0);
    checkOutput("abIdleRead", uart_read_out, 1'b0);
    checkOutput("abIdleAddr", uart_address_out, 32'h0);
    checkOutput("abNoDrop", drop_out, 2'b00);
    @(negedge clk);
    checkOutput("abInitMask", uart_write_mask_out, 4'b0011);
    checkOutput("abInitValue", uart_write_value_out, 32'h0000_0068);
    dataWrites = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (uart_sel_out && uart_address_out == Base + 32'h8) dataWrites++;
      if (drop_out != 2'b00) dataWrites++;
    end
    checkOutput("abNoWrite", dataWrites, 0);
    checkOutput("abIdleBusy", busy_out, 1'b0);

    // Randomized contention run scored by the model.
    for (int i = 0; i < NumBytes; i++) begin
      q0.push_back(8'($urandom_range(0, 255)));
      q1.push_back(8'($urandom_range(0, 255)));
    end
    vld            = 2'b00;
    modelLastGrant = 1'b1;
    inFlight       = 1'b0;
    modelGrant     = 1'b0;
    expByte        = 8'h00;
    pollsDone      = 0;
    awaitingWrite  = 1'b0;
    zerosLeft      = 0;
    pendingDrop    = 2'b00;
    acceptCount    = 0;
    writeCount     = 0;
    dropCount      = 0;
    prevStall      = 1'b0;
    prevBus        = '0;

    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (q0.size() == 0 && q1.size() == 0 && !inFlight) break;
      @(posedge clk); #1;
      applyStimulus();
      @(negedge clk);
      observe();
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      applyStimulus();
      @(negedge clk);
      observe();
    end

    checkOutput("drained", 32'(q0.size() + q1.size()) + {31'h0, inFlight}, 32'h0);
    checkOutput("accepts", acceptCount, 2 * NumBytes);
    checkOutput("completions", writeCount + dropCount, 2 * NumBytes);
    $display("[TB] random run: %0d writes, %0d drops", writeCount, dropCount);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
